// File: rtl/ingredient_pool.sv
// Tracks a pool of identical ingredient sprites: spawn at crates, carry, drop on counters,
// trash, chop on the cutting board and load into the pot. Everything advances once per frame.
module ingredient_pool #(
    parameter int unsigned NUM_ITEMS    = 4,
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned CHOP_PRESSES = 5,
    parameter int unsigned DEBOUNCE     = 3,
    parameter int unsigned HAND_OFFSET  = 20,
    parameter int unsigned IDX_W        = $clog2(NUM_ITEMS + 1)
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [7:0]         keycode,
    input  logic               wallFlag,
    input  logic [3:0]         tileType,
    input  logic [COORD_W-1:0] nearestCounterX,
    input  logic [COORD_W-1:0] nearestCounterY,
    input  logic [COORD_W-1:0] penguinX,
    input  logic [COORD_W-1:0] penguinY,
    input  logic [IDX_W-1:0]   nearestItem,
    input  logic               potAccept,
    output logic [IDX_W-1:0]   heldIndex,
    output logic [COORD_W-1:0] itemX     [NUM_ITEMS],
    output logic [COORD_W-1:0] itemY     [NUM_ITEMS],
    output logic [1:0]         itemState [NUM_ITEMS],
    output logic [3:0]         chopCount,
    output logic               potLoad,
    output logic               poolFull
);

    localparam logic [7:0] KeyE      = 8'h08;
    localparam logic [7:0] KeyQ      = 8'h14;
    localparam logic [1:0] StAbsent  = 2'd0;
    localparam logic [1:0] StRaw     = 2'd1;
    localparam logic [1:0] StChopped = 2'd2;

    logic [COORD_W-1:0] item_x_q  [NUM_ITEMS];
    logic [COORD_W-1:0] item_x_d  [NUM_ITEMS];
    logic [COORD_W-1:0] item_y_q  [NUM_ITEMS];
    logic [COORD_W-1:0] item_y_d  [NUM_ITEMS];
    logic [1:0]         item_st_q [NUM_ITEMS];
    logic [1:0]         item_st_d [NUM_ITEMS];
    logic [IDX_W-1:0]   held_q, held_d;
    logic [IDX_W-1:0]   chop_tgt_q, chop_tgt_d;
    logic [3:0]         chop_cnt_q, chop_cnt_d;
    logic [3:0]         deb_q, deb_d;
    logic               pot_load_q, pot_load_d;
    logic               pool_full_q, pool_full_d;

    logic               key_act, accept, act_e, act_q;
    logic               near_live, near_raw, held_chopped;
    logic [IDX_W-1:0]   free_idx;
    logic [3:0]         cnt_next;
    logic [COORD_W-1:0] hand_x, hand_y;

    assign key_act = (keycode == KeyE) || (keycode == KeyQ);
    assign accept  = key_act && (deb_q >= 4'(DEBOUNCE));
    assign act_e   = accept && (keycode == KeyE) && wallFlag;
    assign act_q   = accept && (keycode == KeyQ);
    assign hand_x  = penguinX + COORD_W'(HAND_OFFSET);
    assign hand_y  = penguinY + COORD_W'(HAND_OFFSET);

    // Per-slot status used by the action decode; free_idx is the lowest absent slot + 1.
    always_comb begin
        near_live    = 1'b0;
        near_raw     = 1'b0;
        held_chopped = 1'b0;
        free_idx     = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_st_q[i] == StAbsent && free_idx == '0) free_idx = IDX_W'(i + 1);
            if (nearestItem == IDX_W'(i + 1)) begin
                near_live = (item_st_q[i] != StAbsent);
                near_raw  = (item_st_q[i] == StRaw);
            end
            if (held_q == IDX_W'(i + 1) && item_st_q[i] == StChopped) held_chopped = 1'b1;
        end
    end

    always_comb begin
        item_x_d    = item_x_q;
        item_y_d    = item_y_q;
        item_st_d   = item_st_q;
        held_d      = held_q;
        chop_tgt_d  = chop_tgt_q;
        chop_cnt_d  = chop_cnt_q;
        pot_load_d  = 1'b0;
        pool_full_d = 1'b0;
        cnt_next    = '0;

        // A held key that is not accepted leaves the counter alone: one press, one action.
        if (!key_act) deb_d = (deb_q < 4'(DEBOUNCE)) ? deb_q + 4'd1 : deb_q;
        else if (accept) deb_d = '0;
        else deb_d = deb_q;

        if (act_e) begin
            if (held_q != '0) begin
                case (tileType)
                    4'd6: begin
                        for (int i = 0; i < NUM_ITEMS; i++)
                            if (held_q == IDX_W'(i + 1)) item_st_d[i] = StAbsent;
                        held_d = '0;
                    end
                    4'd3: begin
                        if (potAccept && held_chopped) begin
                            for (int i = 0; i < NUM_ITEMS; i++)
                                if (held_q == IDX_W'(i + 1)) item_st_d[i] = StAbsent;
                            held_d     = '0;
                            pot_load_d = 1'b1;
                        end
                    end
                    4'd0, 4'd1: begin
                        if (nearestItem == '0) begin
                            for (int i = 0; i < NUM_ITEMS; i++) begin
                                if (held_q == IDX_W'(i + 1)) begin
                                    item_x_d[i] = nearestCounterX;
                                    item_y_d[i] = nearestCounterY;
                                end
                            end
                            held_d = '0;
                        end
                    end
                    default: ;
                endcase
            end else if (near_live) begin
                held_d = nearestItem;
            end else if (tileType == 4'd2) begin
                if (free_idx != '0) begin
                    for (int i = 0; i < NUM_ITEMS; i++)
                        if (free_idx == IDX_W'(i + 1)) item_st_d[i] = StRaw;
                    held_d = free_idx;
                end else begin
                    pool_full_d = 1'b1;
                end
            end
        end

        if (act_q && tileType == 4'd0 && held_q == '0 && near_raw) begin
            cnt_next   = (nearestItem != chop_tgt_q) ? 4'd1 : chop_cnt_q + 4'd1;
            chop_tgt_d = nearestItem;
            if (cnt_next == 4'(CHOP_PRESSES)) begin
                chop_cnt_d = '0;
                for (int i = 0; i < NUM_ITEMS; i++)
                    if (nearestItem == IDX_W'(i + 1)) item_st_d[i] = StChopped;
            end else begin
                chop_cnt_d = cnt_next;
            end
        end

        // The carried item tracks the hand; a drop clears held_d so it keeps its counter spot.
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (held_d == IDX_W'(i + 1)) begin
                item_x_d[i] = hand_x;
                item_y_d[i] = hand_y;
            end
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                item_x_q[i]  <= '0;
                item_y_q[i]  <= '0;
                item_st_q[i] <= StAbsent;
            end
            held_q      <= '0;
            chop_tgt_q  <= '0;
            chop_cnt_q  <= '0;
            deb_q       <= '0;
            pot_load_q  <= 1'b0;
            pool_full_q <= 1'b0;
        end else begin
            item_x_q    <= item_x_d;
            item_y_q    <= item_y_d;
            item_st_q   <= item_st_d;
            held_q      <= held_d;
            chop_tgt_q  <= chop_tgt_d;
            chop_cnt_q  <= chop_cnt_d;
            deb_q       <= deb_d;
            pot_load_q  <= pot_load_d;
            pool_full_q <= pool_full_d;
        end
    end

    assign itemX     = item_x_q;
    assign itemY     = item_y_q;
    assign itemState = item_st_q;
    assign heldIndex = held_q;
    assign chopCount = chop_cnt_q;
    assign potLoad   = pot_load_q;
    assign poolFull  = pool_full_q;

endmodule

// File: tb/tb_ingredient_pool.sv
// Bench for ingredient_pool: directed vector table, hand-written corner sequences and
// randomized frames, all checked against a behavioural model of the pool.
module tb_ingredient_pool;

    localparam int N    = 4;
    localparam int CHOP = 5;
    localparam int DEB  = 3;
    localparam int OFF  = 20;
    localparam logic [7:0] KE = 8'h08;
    localparam logic [7:0] KQ = 8'h14;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kc;
    logic       wall;
    logic [3:0] tile;
    logic [9:0] ncx, ncy, px, py;
    logic [2:0] near;
    logic       pa;
    logic [2:0] held;
    logic [9:0] ix  [N];
    logic [9:0] iy  [N];
    logic [1:0] ist [N];
    logic [3:0] cc;
    logic       pl, pf;

    always #5 clk = ~clk;

    ingredient_pool #(
        .NUM_ITEMS(N), .COORD_W(10), .CHOP_PRESSES(CHOP), .DEBOUNCE(DEB), .HAND_OFFSET(OFF)
    ) dut (
        .frame_clk(clk), .Reset(rst), .keycode(kc), .wallFlag(wall), .tileType(tile),
        .nearestCounterX(ncx), .nearestCounterY(ncy), .penguinX(px), .penguinY(py),
        .nearestItem(near), .potAccept(pa), .heldIndex(held), .itemX(ix), .itemY(iy),
        .itemState(ist), .chopCount(cc), .potLoad(pl), .poolFull(pf)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference state: plain integers, one entry per slot.
    int m_x [N];
    int m_y [N];
    int m_st[N];
    int m_held, m_cnt, m_tgt, m_idle, m_pot, m_full;

    typedef struct {
        logic       rst;
        logic [7:0] kc;
        logic       wall;
        int         tile, px, py, ncx, ncy, near;
        int         e_held, e_st0, e_x0, e_y0, e_cnt;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic model_step();
        int n, h, s, hx, hy;
        bit is_e, is_q, acc;
        m_pot  = 0;
        m_full = 0;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_x[i] = 0; m_y[i] = 0; m_st[i] = 0;
            end
            m_held = 0; m_cnt = 0; m_tgt = 0; m_idle = 0;
        end else begin
            is_e = (kc == KE);
            is_q = (kc == KQ);
            acc  = 0;
            if (!(is_e || is_q)) begin
                if (m_idle < DEB) m_idle++;
            end else if (m_idle >= DEB) begin
                acc    = 1;
                m_idle = 0;
            end
            hx = (int'(px) + OFF) % 1024;
            hy = (int'(py) + OFF) % 1024;
            n  = int'(near);
            if (acc && is_e && wall) begin
                if (m_held != 0) begin
                    h = m_held - 1;
                    if (tile == 6) begin
                        m_st[h] = 0; m_held = 0;
                    end else if (tile == 3) begin
                        if (pa && m_st[h] == 2) begin
                            m_st[h] = 0; m_held = 0; m_pot = 1;
                        end
                    end else if (tile <= 1 && n == 0) begin
                        m_x[h] = int'(ncx); m_y[h] = int'(ncy); m_held = 0;
                    end
                end else if (n >= 1 && n <= N && m_st[n-1] != 0) begin
                    m_held = n;
                end else if (tile == 2) begin
                    s = -1;
                    for (int i = 0; i < N; i++) if (m_st[i] == 0 && s < 0) s = i;
                    if (s < 0) m_full = 1;
                    else begin
                        m_st[s] = 1; m_held = s + 1;
                    end
                end
            end
            if (acc && is_q && tile == 0 && m_held == 0 && n >= 1 && n <= N && m_st[n-1] == 1) begin
                if (n != m_tgt) begin
                    m_tgt = n; m_cnt = 1;
                end else m_cnt++;
                if (m_cnt == CHOP) begin
                    m_st[n-1] = 2; m_cnt = 0;
                end
            end
            if (m_held != 0) begin
                m_x[m_held-1] = hx; m_y[m_held-1] = hy;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("heldIndex", 32'(held), m_held);
        chk("chopCount", 32'(cc), m_cnt);
        chk("potLoad", 32'(pl), m_pot);
        chk("poolFull", 32'(pf), m_full);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("itemX[%0d]", i), 32'(ix[i]), m_x[i]);
            chk($sformatf("itemY[%0d]", i), 32'(iy[i]), m_y[i]);
            chk($sformatf("itemState[%0d]", i), 32'(ist[i]), m_st[i]);
        end
    endtask

    task automatic idle(input int n);
        kc = 8'h00;
        repeat (n) cycle();
    endtask

    task automatic press(input logic [7:0] k);
        idle(DEB);
        kc = k;
        cycle();
        kc = 8'h00;
    endtask

    task automatic add(input logic r, input logic [7:0] k, input int tl, input int x, input int y,
                       input int cx, input int cy, input int nr, input int eh, input int es,
                       input int ex, input int ey, input int ec);
        vec_t v;
        v.rst = r; v.kc = k; v.wall = 1'b1; v.tile = tl; v.px = x; v.py = y;
        v.ncx = cx; v.ncy = cy; v.near = nr;
        v.e_held = eh; v.e_st0 = es; v.e_x0 = ex; v.e_y0 = ey; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; kc = 8'h00; wall = 1'b1; tile = 4'd0; ncx = '0; ncy = '0;
        px = '0; py = '0; near = '0; pa = 1'b0;

        // Spawn, follow, debounce, put-down and a full chop of item 1.
        add(1, 8'h00, 2, 100, 200, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) add(0, 8'h00, 2, 100, 200, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) add(0, KE, 2, 100, 200, 0, 0, 0, 1, 1, 120, 220, 0);
        add(0, 8'h00, 2, 130, 200, 0, 0, 0, 1, 1, 150, 220, 0);
        add(0, 8'h00, 1, 130, 200, 380, 220, 0, 1, 1, 150, 220, 0);
        add(0, KE, 1, 130, 200, 380, 220, 0, 1, 1, 150, 220, 0);
        add(0, 8'h00, 1, 130, 200, 380, 220, 0, 1, 1, 150, 220, 0);
        add(0, KE, 1, 130, 200, 380, 220, 0, 0, 1, 380, 220, 0);
        for (int p = 1; p <= CHOP; p++) begin
            repeat (3) add(0, 8'h00, 0, 130, 200, 380, 220, 1, 0, 1, 380, 220, p - 1);
            add(0, KQ, 0, 130, 200, 380, 220, 1, 0, (p == CHOP) ? 2 : 1, 380, 220,
                (p == CHOP) ? 0 : p);
        end

        for (int k = 0; k < vecs.size(); k++) begin
            rst = vecs[k].rst; kc = vecs[k].kc; wall = vecs[k].wall;
            tile = 4'(vecs[k].tile); px = 10'(vecs[k].px); py = 10'(vecs[k].py);
            ncx = 10'(vecs[k].ncx); ncy = 10'(vecs[k].ncy); near = 3'(vecs[k].near);
            cycle();
            chk($sformatf("v%0d_held", k), 32'(held), vecs[k].e_held);
            chk($sformatf("v%0d_st0", k), 32'(ist[0]), vecs[k].e_st0);
            chk($sformatf("v%0d_x0", k), 32'(ix[0]), vecs[k].e_x0);
            chk($sformatf("v%0d_y0", k), 32'(iy[0]), vecs[k].e_y0);
            chk($sformatf("v%0d_cnt", k), 32'(cc), vecs[k].e_cnt);
        end

        // Fill the pool, refuse a fifth spawn, then trash item 2 and reuse its slot.
        rst = 1'b1; kc = 8'h00; cycle(); rst = 1'b0;
        wall = 1'b1;
        for (int k = 0; k < N; k++) begin
            tile = 4'd2; near = '0; press(KE);
            tile = 4'd1; ncx = 10'(40 * k); ncy = 10'd100; press(KE);
        end
        tile = 4'd2; near = '0; idle(DEB);
        kc = KE; cycle();
        chk("pool_full_pulse", 32'(pf), 1);
        chk("pool_full_no_hold", 32'(held), 0);
        kc = 8'h00; cycle();
        chk("pool_full_clear", 32'(pf), 0);
        tile = 4'd1; near = 3'd2; press(KE);
        chk("pickup_item2", 32'(held), 2);
        tile = 4'd6; press(KE);
        chk("trash_state", 32'(ist[1]), 0);
        chk("trash_held", 32'(held), 0);
        tile = 4'd2; near = '0; press(KE);
        chk("reuse_slot1_held", 32'(held), 2);
        chk("reuse_slot1_state", 32'(ist[1]), 1);

        // Pot: chopped item refused then accepted; a raw item is never accepted.
        tile = 4'd0; near = '0; ncx = 10'd500; ncy = 10'd300; press(KE);
        near = 3'd2;
        repeat (CHOP) press(KQ);
        chk("item2_chopped", 32'(ist[1]), 2);
        press(KE);
        tile = 4'd3; pa = 1'b0; press(KE);
        chk("pot_refused_held", 32'(held), 2);
        chk("pot_refused_pulse", 32'(pl), 0);
        pa = 1'b1; press(KE);
        chk("pot_load_pulse", 32'(pl), 1);
        chk("pot_load_state", 32'(ist[1]), 0);
        chk("pot_load_held", 32'(held), 0);
        kc = 8'h00; cycle();
        chk("pot_load_clear", 32'(pl), 0);
        tile = 4'd1; near = 3'd1; press(KE);
        tile = 4'd3; press(KE);
        chk("pot_raw_held", 32'(held), 1);
        chk("pot_raw_state", 32'(ist[0]), 1);

        // Reset while carrying a partly chopped item; the first post-reset E is ignored.
        tile = 4'd1; near = '0; press(KE);
        tile = 4'd0; near = 3'd3; press(KQ); press(KQ); press(KE);
        chk("pre_reset_held", 32'(held), 3);
        chk("pre_reset_cnt", 32'(cc), 2);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("reset_held", 32'(held), 0);
        chk("reset_cnt", 32'(cc), 0);
        chk("reset_state2", 32'(ist[2]), 0);
        tile = 4'd2; near = '0; kc = KE; cycle();
        chk("post_reset_e_ignored", 32'(held), 0);
        kc = 8'h00;

        // Randomized frames.
        for (int t = 0; t < 3000; t++) begin
            int r;
            int tiles[9] = '{0, 1, 2, 3, 6, 8, 9, 10, 4};
            r = $urandom_range(0, 9);
            kc = (r < 4) ? 8'h00 : (r < 7) ? KE : (r < 9) ? KQ : 8'h41;
            rst  = ($urandom_range(0, 199) == 0);
            wall = ($urandom_range(0, 3) != 0);
            tile = 4'(tiles[$urandom_range(0, 8)]);
            near = 3'($urandom_range(0, N));
            pa   = 1'($urandom_range(0, 1));
            px   = 10'($urandom_range(0, 1023));
            py   = 10'($urandom_range(0, 1023));
            ncx  = 10'($urandom_range(0, 1023));
            ncy  = 10'($urandom_range(0, 1023));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
